para_rom_arbiter: RTL

Round-robin read controller for the 16-bit parameter ROM in the neural-circuit datapath. It shares one combinational parameter ROM among NREQ neuron/synapse units. Each unit issues a req/ack address request; the controller sequences the ROM address and read-enable, then returns the word with the requester ID. An optional burst mode streams consecutive parameter words to one requester.

---
 rtl/para_rom_arbiter.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/para_rom_arbiter.sv
// ---------------------------------------------------------------------------
// para_rom_arbiter
//
// Round-robin read controller that shares one combinational parameter ROM
// among NREQ neuron/synapse units. A unit raises req with a start address;
// the controller grants it (one-cycle ack pulse), drives the ROM address and
// read-enable for one READ cycle per word, and returns each word one cycle
// later together with the requester ID, the word address and a last flag.
//
// Optional feature macro: PARA_ARB_BURST_EN
//   defined     : req_burst is honoured; a burst streams consecutive words
//                 from the start address up to DEPTH-1 (or stops early at an
//                 out-of-range address).
//   not defined : req_burst is ignored; every transaction is one word and
//                 rsp_last is always 1 together with rsp_valid.
//
// Handshake: req is a level held by the requester until it sees its ack bit;
// ack is a one-cycle pulse. Responses have no backpressure: every cycle with
// rsp_valid = 1 carries one word that the consumer must take.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   synchronous, active-high reset
//   req          in   [NREQ]     per-requester request level
//   req_addr     in   [NREQ*AW]  start addresses, slice i = [i*AW +: AW]
//   req_burst    in   [NREQ]     per-requester burst flag
//   ack          out  [NREQ]     one-hot grant pulse
//   rsp_valid    out            response word valid
//   rsp_id       out  [IW]      requester owning the word
//   rsp_addr     out  [AW]      address of the word
//   rsp_data     out  [DW]      parameter word (all-ones when out of range)
//   rsp_last     out            final word of the transaction
//   busy         out            FSM is in READ (doubles as the state view)
//   rom_addr     out  [AW]      ROM address (0 in IDLE)
//   rom_read_en  out            ROM read enable
//   rom_data     in   [DW]      ROM data, combinational from rom_addr
// ---------------------------------------------------------------------------
module para_rom_arbiter #(
    parameter int NREQ  = 4,
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int DW    = 16,
    parameter int IW    = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ-1:0]    req_burst,
    output logic [NREQ-1:0]    ack,
    output logic               rsp_valid,
    output logic [IW-1:0]      rsp_id,
    output logic [AW-1:0]      rsp_addr,
    output logic [DW-1:0]      rsp_data,
    output logic               rsp_last,
    output logic               busy,
    output logic [AW-1:0]      rom_addr,
    output logic               rom_read_en,
    input  logic [DW-1:0]      rom_data
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   cur_id_q, cur_id_d;
    logic [AW-1:0]   cur_addr_q, cur_addr_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [IW-1:0]   rsp_id_q, rsp_id_d;
    logic [AW-1:0]   rsp_addr_q, rsp_addr_d;
    logic [DW-1:0]   rsp_data_q, rsp_data_d;
    logic            rsp_last_q, rsp_last_d;

`ifdef PARA_ARB_BURST_EN
    logic            burst_q, burst_d;
`else
    // req_burst has no effect in the single-word build.
    logic            unused_burst;
    assign unused_burst = ^req_burst;
`endif

    // Arbitration: first asserted request at or after rr_ptr, wrapping.
    logic            grant_found;
    logic [IW-1:0]   grant_idx;
    int              scan_idx;

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = 0;
        for (int i = 0; i < NREQ; i++) begin
            scan_idx = (int'(rr_ptr_q) + i) % NREQ;
            if (!grant_found && req[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = IW'(scan_idx);
            end
        end
    end

    // Range checks use one extra bit so DEPTH == 2**AW compares correctly.
    logic in_range;
    logic at_end;
    logic word_last;

    assign in_range = ({1'b0, cur_addr_q} <  (AW+1)'(DEPTH));
    assign at_end   = ({1'b0, cur_addr_q} >= (AW+1)'(DEPTH - 1));

`ifdef PARA_ARB_BURST_EN
    assign word_last = !burst_q || at_end || !in_range;
`else
    assign word_last = 1'b1;
    logic unused_at_end;
    assign unused_at_end = at_end;
`endif

    // Next-state and ROM-side outputs.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        cur_id_d    = cur_id_q;
        cur_addr_d  = cur_addr_q;
`ifdef PARA_ARB_BURST_EN
        burst_d     = burst_q;
`endif
        ack_d       = '0;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        rsp_addr_d  = rsp_addr_q;
        rsp_data_d  = rsp_data_q;
        rsp_last_d  = 1'b0;
        rom_addr    = '0;
        rom_read_en = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    cur_id_d   = grant_idx;
                    cur_addr_d = req_addr[int'(grant_idx)*AW +: AW];
`ifdef PARA_ARB_BURST_EN
                    burst_d    = req_burst[grant_idx];
`endif
                    ack_d[grant_idx] = 1'b1;
                    rr_ptr_d   = IW'((int'(grant_idx) + 1) % NREQ);
                    state_d    = READ;
                end
            end
            READ: begin
                rom_addr    = cur_addr_q;
                rom_read_en = in_range;
                rsp_valid_d = 1'b1;
                rsp_id_d    = cur_id_q;
                rsp_addr_d  = cur_addr_q;
                rsp_data_d  = in_range ? rom_data : {DW{1'b1}};
                rsp_last_d  = word_last;
                if (word_last) begin
                    state_d = IDLE;
                end else begin
                    cur_addr_d = cur_addr_q + AW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            cur_id_q    <= '0;
            cur_addr_q  <= '0;
`ifdef PARA_ARB_BURST_EN
            burst_q     <= 1'b0;
`endif
            ack_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_addr_q  <= '0;
            rsp_data_q  <= '0;
            rsp_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            cur_id_q    <= cur_id_d;
            cur_addr_q  <= cur_addr_d;
`ifdef PARA_ARB_BURST_EN
            burst_q     <= burst_d;
`endif
            ack_q       <= ack_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_addr_q  <= rsp_addr_d;
            rsp_data_q  <= rsp_data_d;
            rsp_last_q  <= rsp_last_d;
        end
    end

    assign ack       = ack_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_addr  = rsp_addr_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_last  = rsp_last_q;
    assign busy      = (state_q == READ);

endmodule
